// File: rtl/multi_digit_segment_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// Digits are double-buffered (shadow -> active only at frame wrap).
// Each digit slot starts with a dead subslot, then PWM-gated anodes.
// Leading-zero blanking, per-digit blink and decimal points are supported.
// Every output is registered. The registers hold the pattern for the
// scan position that the counters move to on that edge.
module multi_digit_segment_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int REFRESH_HZ = 1000,
    parameter int DIM_BITS   = 3,
    parameter int BLINK_HZ   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode_signals,
    output logic [6:0]              display_out,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int SUBN = 1 << DIM_BITS;
    localparam int SLOT = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int SUB  = SLOT / SUBN;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW   = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DW   = $clog2(NUM_DIGITS);

    localparam logic [SW-1:0]       SUB_LAST  = SW'(SUB - 1);
    localparam logic [DIM_BITS-1:0] K_LAST    = DIM_BITS'(SUBN - 1);
    localparam logic [BW-1:0]       HALF_LAST = BW'(HALF - 1);
    localparam logic [DW-1:0]       DIG_LEFT  = DW'(NUM_DIGITS - 1);

    // Timing must split evenly into PWM subslots.
    generate
        if (SLOT == 0 || (SLOT % SUBN) != 0 || HALF == 0 || NUM_DIGITS < 2) begin : g_bad_cfg
            $error("multi_digit_segment_driver: SLOT must be a non-zero multiple of 2^DIM_BITS");
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111110;
        endcase
    endfunction

    // Scan position, blink phase and buffers.
    logic [SW-1:0]           sub_q, sub_d;
    logic [DIM_BITS-1:0]     k_q, k_d;
    logic [DW-1:0]           dig_q, dig_d;
    logic [BW-1:0]           blk_q, blk_d;
    logic                    blk_on_q, blk_on_d;
    logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;

    // Registered outputs.
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    sub_end, slot_end, wrap, blk_end, vis, zl;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [3:0]              nib;

    // Next scan position, buffer transfer and output pattern for that position.
    always_comb begin
        sub_end  = (sub_q == SUB_LAST);
        slot_end = sub_end && (k_q == K_LAST);
        wrap     = slot_end && (dig_q == '0);

        sub_d = sub_end ? '0 : sub_q + SW'(1);
        k_d   = sub_end ? k_q + DIM_BITS'(1) : k_q;
        dig_d = dig_q;
        if (slot_end) dig_d = (dig_q == '0) ? DIG_LEFT : dig_q - DW'(1);

        blk_end  = (blk_q == HALF_LAST);
        blk_d    = blk_end ? '0 : blk_q + BW'(1);
        blk_on_d = blk_end ? ~blk_on_q : blk_on_q;

        sh_dig_d  = load ? digits_bcd : sh_dig_q;
        sh_dp_d   = load ? dp_in : sh_dp_q;
        act_dig_d = wrap ? sh_dig_d : act_dig_q;
        act_dp_d  = wrap ? sh_dp_d : act_dp_q;

        // A digit is leading-blanked when it and everything left of it are zero.
        zl     = 1'b1;
        lz_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zl        = zl && (act_dig_d[4*i +: 4] == 4'd0);
            lz_vec[i] = zl && blank_lz && (i != 0);
        end

        nib = act_dig_d[4*int'(dig_d) +: 4];
        vis = !lz_vec[dig_d] && !(blink_mask[dig_d] && !blk_on_d);

        seg_d = vis ? seg7(nib) : 7'b1111111;
        dp_d  = vis ? ~act_dp_d[dig_d] : 1'b1;
        an_d  = '1;
        if (vis && (k_d != '0) && (k_d <= brightness)) an_d[dig_d] = 1'b0;

        fd_d = (dig_d == '0) && (k_d == K_LAST) && (sub_d == SUB_LAST);
    end

    // State registers; reset parks the scan at the leftmost digit's dead subslot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sub_q     <= '0;
            k_q       <= '0;
            dig_q     <= DIG_LEFT;
            blk_q     <= '0;
            blk_on_q  <= 1'b1;
            sh_dig_q  <= '0;
            sh_dp_q   <= '0;
            act_dig_q <= '0;
            act_dp_q  <= '0;
        end else begin
            sub_q     <= sub_d;
            k_q       <= k_d;
            dig_q     <= dig_d;
            blk_q     <= blk_d;
            blk_on_q  <= blk_on_d;
            sh_dig_q  <= sh_dig_d;
            sh_dp_q   <= sh_dp_d;
            act_dig_q <= act_dig_d;
            act_dp_q  <= act_dp_d;
        end
    end

    // Output registers; display dark while in reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            an_q  <= '1;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= fd_d;
        end
    end

    assign anode_signals = an_q;
    assign display_out   = seg_q;
    assign dp_out        = dp_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_multi_digit_segment_driver.sv
// Self-checking bench for multi_digit_segment_driver.
// The reference model tracks the number of clock edges since reset.
// Slot, subslot, digit and blink phase are derived from that count arithmetically.
module tb_multi_digit_segment_driver;

    localparam int ND    = 4;
    localparam int CLKHZ = 3200;
    localparam int REFHZ = 100;
    localparam int DB    = 3;
    localparam int BLKHZ = 50;
    localparam int SLOT  = CLKHZ / (REFHZ * ND);
    localparam int SUB   = SLOT / (1 << DB);
    localparam int HALF  = CLKHZ / (2 * BLKHZ);
    localparam int FRAME = SLOT * ND;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [4*ND-1:0] digits_bcd = '0;
    logic [ND-1:0]   dp_in = '0;
    logic            load = 1'b0;
    logic            blank_lz = 1'b0;
    logic [ND-1:0]   blink_mask = '0;
    logic [DB-1:0]   brightness = '0;
    logic [ND-1:0]   anode_signals;
    logic [6:0]      display_out;
    logic            dp_out;
    logic            frame_done;

    int checks = 0;
    int errors = 0;

    // Reference state
    int              e = 0;
    logic [4*ND-1:0] sh = '0, act = '0;
    logic [ND-1:0]   shdp = '0, actdp = '0;

    multi_digit_segment_driver #(
        .NUM_DIGITS(ND), .CLK_HZ(CLKHZ), .REFRESH_HZ(REFHZ),
        .DIM_BITS(DB), .BLINK_HZ(BLKHZ)
    ) dut (
        .clock(clock), .reset(reset), .digits_bcd(digits_bcd), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .blink_mask(blink_mask),
        .brightness(brightness), .anode_signals(anode_signals),
        .display_out(display_out), .dp_out(dp_out), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] ref_seg(input int n);
        case (n)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    // One clock edge: update the model from inputs seen at the edge, then check outputs.
    task automatic tick();
        int d, k;
        logic off, lz, vis;
        logic [ND-1:0] x_an;
        logic [6:0] x_seg;
        logic x_dp, x_fd;
        @(posedge clock);
        if (!reset) begin
            e = 0; sh = '0; shdp = '0; act = '0; actdp = '0;
        end else begin
            e++;
            if (load) begin sh = digits_bcd; shdp = dp_in; end
            if (e % FRAME == 0) begin act = sh; actdp = shdp; end
        end
        #1;
        x_an = '1; x_seg = 7'b1111111; x_dp = 1'b1; x_fd = 1'b0;
        if (e > 0) begin
            k   = (e % SLOT) / SUB;
            d   = ND - 1 - ((e / SLOT) % ND);
            off = ((e / HALF) % 2) == 1;
            lz  = blank_lz && (d != 0) && ((act >> (4 * d)) == 0);
            vis = !lz && !(blink_mask[d] && off);
            if (vis) begin
                x_seg = ref_seg(int'((act >> (4 * d)) & 16'hF));
                x_dp  = ~actdp[d];
                if (k >= 1 && k <= int'(brightness)) x_an[d] = 1'b0;
            end
            x_fd = (e % FRAME) == FRAME - 1;
        end
        chk("anode", 32'(anode_signals), 32'(x_an));
        chk("segments", 32'(display_out), 32'(x_seg));
        chk("dp", 32'(dp_out), 32'(x_dp));
        chk("frame_done", 32'(frame_done), 32'(x_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] dg, input logic [3:0] dp);
        digits_bcd = dg; dp_in = dp; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Advance until the model position within a frame equals p (bounded).
    task automatic goto_pos(input int p);
        for (int n = 0; n < 2 * FRAME && (e % FRAME) != p; n++) tick();
    endtask

    initial begin
        // Reset held with a load pending
        reset = 1'b0; load = 1'b1; digits_bcd = 16'h1234; brightness = 3'd7;
        run(3);
        reset = 1'b1; load = 1'b0;
        run(40);

        // Basic scan 1259 with dp on digit 2
        do_load(16'h1259, 4'b0100);
        run(80);

        // Mid-frame load during digit 2
        goto_pos(10);
        do_load(16'h5678, 4'b0001);
        run(70);

        // Load landing exactly on the frame-wrap edge
        goto_pos(FRAME - 1);
        do_load(16'h4321, 4'b1000);
        run(40);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0007, 4'b0000); run(70);
        do_load(16'h0000, 4'b0000); run(70);
        do_load(16'h0105, 4'b0010); run(70);

        // Brightness
        brightness = 3'd2; run(40);
        brightness = 3'd0; run(40);
        brightness = 3'd7;

        // Blink with dash digits
        blank_lz = 1'b0; blink_mask = 4'b0001;
        do_load(16'h00AB, 4'b0000);
        run(160);

        // Reset mid-frame
        goto_pos(13);
        reset = 1'b0; run(2); reset = 1'b1;
        run(40);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                digits_bcd = 16'($urandom);
                if ($urandom_range(0, 2) == 0) digits_bcd = digits_bcd & 16'h00FF;
                if ($urandom_range(0, 4) == 0) digits_bcd = digits_bcd & 16'h000F;
                dp_in = 4'($urandom);
            end
            if ($urandom_range(0, 63) == 0) brightness = 3'($urandom);
            if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
            reset = ($urandom_range(0, 799) != 0);
            tick();
        end
        reset = 1'b1; load = 1'b0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
